video_mode_ctrl: RTL
====================

Name: video_mode_ctrl

Overview:
Frame-synchronous controller for the video output mux select lines.
- Takes user button presses and an auto-demo enable, and produces the background select (bg_out, 4 modes) and target-overlay select (target_out).
- Select changes are staged in pending registers and committed only on a new-frame pulse, so the displayed image never switches mid-frame.
- Sits in the pixel-clock domain, between the debounced button logic and the video mux.

Parameters:
DWELL_FRAMES, 120, frames each mode is shown in AUTO before advancing (>=1)
HOLD_FRAMES, 300, frames auto-advance is paused after a manual press in AUTO (>=1)
RESET_BG, 2'b00, bg_out/pending background value after reset

Ports:
clk_pixel_in  input  1  pixel clock; all logic on rising edge
rst_in  input  1  synchronous, active-high reset
btn_bg_in  input  1  debounced level; rising edge advances background mode
btn_target_in  input  1  debounced level; rising edge toggles target overlay
auto_in  input  1  level; high enables auto-cycle demo
new_frame_in  input  1  one-cycle pulse at frame start
bg_out  output  2  committed background select to mux
target_out  output  1  committed target select to mux
auto_active_out  output  1  high while FSM in AUTO (not HOLD/MANUAL)
mode_changed_out  output  1  one-cycle pulse when a commit changes bg_out or target_out

Behaviour:
- Reset (rst_in high at clock edge):
  - bg_out = pend_bg = RESET_BG; target_out = pend_tgt = 0.
  - btn_q registers = 0; state = MANUAL.
  - frame_cnt = 0; auto_active_out = 0; mode_changed_out = 0.
  - Reset mid-operation discards pending changes and counts.
- Edge detect:
  - press_bg = btn_bg_in & ~btn_bg_q; press_tgt likewise.
  - btn_q registered every cycle, so holding a button produces exactly one press.
- Pending update, at the edge where a press is seen:
  - press_bg: pend_bg <= pend_bg + 1, mod 4 (3 wraps to 0).
  - press_tgt: pend_tgt <= ~pend_tgt.
  - Both in the same cycle: both apply.
- Commit, at the edge where new_frame_in = 1:
  - bg_out <= pend_bg; target_out <= pend_tgt, using pending values as registered before this edge.
  - A press or auto-advance in the same cycle lands in pending and commits at the next frame.
  - Latency: a press before frame N's pulse is visible the cycle after frame N's pulse.
- mode_changed_out:
  - Registered; high for exactly the one cycle after a commit edge where (pend_bg, pend_tgt) != (bg_out, target_out).
  - Otherwise 0.
- FSM states and transitions:
  - MANUAL:
    - frame_cnt held at 0.
    - To AUTO when auto_in = 1 (frame_cnt = 0).
  - AUTO:
    - Each new_frame_in increments frame_cnt.
    - On the new_frame_in where frame_cnt == DWELL_FRAMES-1: frame_cnt <= 0 and pend_bg advances mod 4.
    - If that advance wraps 3->0, pend_tgt also toggles.
    - Any press (press_bg or press_tgt): to HOLD, frame_cnt <= 0; the press applies and the auto-advance for that cycle is suppressed (button wins).
    - auto_in = 0: to MANUAL, frame_cnt <= 0.
  - HOLD:
    - Each new_frame_in increments frame_cnt.
    - Another press restarts frame_cnt at 0.
    - On the new_frame_in where frame_cnt == HOLD_FRAMES-1: to AUTO with frame_cnt <= 0.
    - auto_in = 0 exits to MANUAL immediately (priority over the count).
- auto_active_out = (state == AUTO), registered with the state.
- Counter width: $clog2(max(DWELL_FRAMES, HOLD_FRAMES)+1); counters never exceed the limit.
- new_frame_in held high for multiple cycles is illegal input; each high cycle counts as a frame.

Test Plan:
1. Reset, then 3 btn_bg rising edges (held 5 cycles each) before one new_frame pulse -> bg_out stays 00 until the pulse, then 11; mode_changed_out high exactly 1 cycle; holding the button gives no extra steps.
2. bg at 11, one btn_bg press, then new_frame -> bg_out = 00 (wrap); btn_target press plus new_frame in the same cycle -> target_out unchanged that frame, 1 at the next frame.
3. DWELL_FRAMES = 2, auto_in = 1, 16 frames from bg 00/tgt 0 -> pend_bg advances every 2 frames and commits the following frame; after bg 11->00, target_out = 1; auto_active_out = 1 throughout.
4. AUTO with DWELL = 2, HOLD = 3; press btn_bg on the cycle of a would-be advance -> only +1 total, state HOLD; 3 frames of no advance; second press mid-hold restarts count; then AUTO resumes.
5. auto_in dropped during HOLD -> MANUAL next edge; no further advances over 10 frames; auto_active_out = 0.
6. Assert rst_in with pending changes and frame_cnt nonzero -> all outputs at reset values next cycle; the following new_frame gives bg_out = RESET_BG and no mode_changed_out pulse.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Frame-synchronous background/target select controller for the video output mux.
// Button presses and auto-demo advances stage in pending registers and are committed on new_frame_in.
module video_mode_ctrl #(
  parameter int unsigned DWELL_FRAMES = 120,
  parameter int unsigned HOLD_FRAMES  = 300,
  parameter logic [1:0]  RESET_BG     = 2'b00
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       auto_in,
  input  logic       new_frame_in,
  output logic [1:0] bg_out,
  output logic       target_out,
  output logic       auto_active_out,
  output logic       mode_changed_out
);

  localparam int unsigned MAX_FRAMES = (DWELL_FRAMES > HOLD_FRAMES) ? DWELL_FRAMES : HOLD_FRAMES;
  localparam int unsigned CW         = $clog2(MAX_FRAMES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_HOLD   = 2'b10
  } state_e;

  function automatic logic [1:0] bg_step(input logic [1:0] v);
    return v + 2'd1;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_bg_q, btn_tgt_q;
  logic [1:0]    pend_bg_q, pend_bg_d;
  logic          pend_tgt_q, pend_tgt_d;
  logic [1:0]    bg_q, bg_d;
  logic          tgt_q, tgt_d;
  logic          changed_q, changed_d;
  logic          auto_active_q;

  logic press_bg_s, press_tgt_s, press_any_s, advance_s;

  assign press_bg_s  = btn_bg_in & ~btn_bg_q;
  assign press_tgt_s = btn_target_in & ~btn_tgt_q;
  assign press_any_s = press_bg_s | press_tgt_s;

  // Mode FSM and frame counter; a press or auto_in low pre-empts the dwell advance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    advance_s = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        cnt_d = CNT_ZERO;
        if (auto_in) begin
          state_d = ST_AUTO;
        end else begin
          state_d = ST_MANUAL;
        end
      end
      ST_AUTO: begin
        if (!auto_in) begin
          state_d = ST_MANUAL;
          cnt_d   = CNT_ZERO;
        end else if (press_any_s) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (new_frame_in) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d     = CNT_ZERO;
            advance_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HOLD: begin
        if (!auto_in) begin
          state_d = ST_MANUAL;
          cnt_d   = CNT_ZERO;
        end else if (press_any_s) begin
          cnt_d = CNT_ZERO;
        end else if (new_frame_in) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_AUTO;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pending update and frame-boundary commit; commit uses pending values from before this edge.
  always_comb begin
    pend_bg_d  = pend_bg_q;
    pend_tgt_d = pend_tgt_q;
    if (press_bg_s || advance_s) begin
      pend_bg_d = bg_step(pend_bg_q);
    end else begin
      pend_bg_d = pend_bg_q;
    end
    if (press_tgt_s || (advance_s && (pend_bg_q == 2'b11))) begin
      pend_tgt_d = ~pend_tgt_q;
    end else begin
      pend_tgt_d = pend_tgt_q;
    end
    if (new_frame_in) begin
      bg_d      = pend_bg_q;
      tgt_d     = pend_tgt_q;
      changed_d = (pend_bg_q != bg_q) || (pend_tgt_q != tgt_q);
    end else begin
      bg_d      = bg_q;
      tgt_d     = tgt_q;
      changed_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q       <= ST_MANUAL;
      cnt_q         <= CNT_ZERO;
      btn_bg_q      <= 1'b0;
      btn_tgt_q     <= 1'b0;
      pend_bg_q     <= RESET_BG;
      pend_tgt_q    <= 1'b0;
      bg_q          <= RESET_BG;
      tgt_q         <= 1'b0;
      changed_q     <= 1'b0;
      auto_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_bg_q      <= btn_bg_in;
      btn_tgt_q     <= btn_target_in;
      pend_bg_q     <= pend_bg_d;
      pend_tgt_q    <= pend_tgt_d;
      bg_q          <= bg_d;
      tgt_q         <= tgt_d;
      changed_q     <= changed_d;
      auto_active_q <= (state_d == ST_AUTO);
    end
  end

  assign bg_out           = bg_q;
  assign target_out       = tgt_q;
  assign auto_active_out  = auto_active_q;
  assign mode_changed_out = changed_q;

endmodule
